// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the shared memory port.
// slave = the arbiter, master = the requesters plus the memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_done;
  logic [15:0]           if_rdata;
  logic                  if_err;

  logic                  d_req;
  logic                  d_wr;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [15:0]           d_wdata;
  logic                  d_gnt;
  logic                  d_done;
  logic [15:0]           d_rdata;
  logic                  d_err;

  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic [15:0]           mem_rdata;

  logic                  busy;

  modport slave (
    input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_done, if_rdata, if_err,
    output d_gnt, d_done, d_rdata, d_err,
    output mem_en, mem_wr, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_done, if_rdata, if_err,
    input  d_gnt, d_done, d_rdata, d_err,
    input  mem_en, mem_wr, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch (read-only) and data (read/write) accesses onto one memory
// port: IDLE -> ACCESS (gnt, strobe) -> RESP (done), data-first with a fetch starvation bound.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                state;
  logic                  owner_d;
  logic                  wr_q;
  logic                  err_q;
  logic [3:0]            starve_cnt;

  logic                  if_gnt, if_done, if_err;
  logic                  d_gnt, d_done, d_err;
  logic [15:0]           if_rdata, d_rdata;
  logic                  mem_en, mem_wr, busy;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;

  logic                  take;
  logic                  pick_d;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [15:0]           rd_word;

  always_comb begin
    take     = bus.if_req | bus.d_req;
    // data has priority unless fetch has already waited out the limit
    pick_d   = bus.d_req & ~(bus.if_req & (starve_cnt == LIMIT));
    sel_addr = pick_d ? bus.d_addr : bus.if_addr;
    sel_wr   = pick_d & bus.d_wr;
    rd_word  = (err_q | wr_q) ? 16'h0 : bus.mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      starve_cnt <= 4'd0;
      if_gnt     <= 1'b0;
      if_done    <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= 16'h0;
      d_gnt      <= 1'b0;
      d_done     <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= 16'h0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 16'h0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state   <= ACCESS;
            busy    <= 1'b1;
            owner_d <= pick_d;
            wr_q    <= sel_wr;
            err_q   <= sel_addr[0];
            if_gnt  <= ~pick_d;
            d_gnt   <= pick_d;
            mem_en  <= ~sel_addr[0];
            mem_wr  <= sel_wr & ~sel_addr[0];
            // misaligned accesses leave the memory bus untouched
            if (!sel_addr[0]) begin
              mem_addr <= sel_addr;
              if (pick_d) mem_wdata <= bus.d_wdata;
            end
          end
          if (!bus.if_req || (take && !pick_d)) starve_cnt <= 4'd0;
          else if (pick_d && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
        end
        ACCESS: begin
          state  <= RESP;
          if_gnt <= 1'b0;
          d_gnt  <= 1'b0;
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          if (owner_d) begin
            d_done  <= 1'b1;
            d_rdata <= rd_word;
            d_err   <= err_q;
          end else begin
            if_done  <= 1'b1;
            if_rdata <= rd_word;
            if_err   <= err_q;
          end
        end
        RESP: begin
          state   <= IDLE;
          busy    <= 1'b0;
          if_done <= 1'b0;
          d_done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.if_done   = if_done;
  assign bus.if_rdata  = if_rdata;
  assign bus.if_err    = if_err;
  assign bus.d_gnt     = d_gnt;
  assign bus.d_done    = d_done;
  assign bus.d_rdata   = d_rdata;
  assign bus.d_err     = d_err;
  assign bus.mem_en    = mem_en;
  assign bus.mem_wr    = mem_wr;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed traffic on both ports; expected responses come from a
// reference memory image and are checked by a done-driven scoreboard monitor.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int SL = 4;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
  mem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (.clk(clk), .rst(rst), .bus(bus));

  // memory: combinational read, write on the edge ending a strobed cycle
  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr[8:1]];
  always @(posedge clk) if (bus.mem_en && bus.mem_wr) mem[bus.mem_addr[8:1]] <= bus.mem_wdata;

  int    checks = 0;
  int    errors = 0;
  resp_t fq[$];
  resp_t dq[$];
  resp_t last_f = '0;
  resp_t last_d = '0;
  resp_t mon_e;
  logic  prev_en = 1'b0;
  logic  rst_q = 1'b0;
  int    en_cnt = 0;
  int    wr_cnt = 0;
  int    cyc = 0;
  bit    log_gnt = 1'b0;
  bit    gl_who[$];
  int    gl_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    cyc++;
    if (!rst_q) begin
      check("reset_ctl", {bus.if_gnt, bus.if_done, bus.if_err, bus.d_gnt, bus.d_done,
                          bus.d_err, bus.mem_en, bus.mem_wr, bus.busy}, 0);
      check("reset_rdata", {bus.if_rdata, bus.d_rdata}, 0);
      check("reset_mem", {bus.mem_addr, bus.mem_wdata}, 0);
      last_f  = '0;
      last_d  = '0;
      prev_en = 1'b0;
    end else begin
      if (bus.if_done) begin
        check("if_done_expected", fq.size() != 0, 1);
        if (fq.size() != 0) begin
          mon_e = fq.pop_front();
          check("if_rdata", bus.if_rdata, mon_e.rdata);
          check("if_err", bus.if_err, mon_e.err);
          last_f = mon_e;
        end
      end else begin
        check("if_hold", {bus.if_err, bus.if_rdata}, {last_f.err, last_f.rdata});
      end
      if (bus.d_done) begin
        check("d_done_expected", dq.size() != 0, 1);
        if (dq.size() != 0) begin
          mon_e = dq.pop_front();
          check("d_rdata", bus.d_rdata, mon_e.rdata);
          check("d_err", bus.d_err, mon_e.err);
          last_d = mon_e;
        end
      end else begin
        check("d_hold", {bus.d_err, bus.d_rdata}, {last_d.err, last_d.rdata});
      end
      if (bus.mem_en) begin
        check("mem_en_single", prev_en, 0);
        en_cnt++;
        if (bus.mem_wr) wr_cnt++;
      end
      check("mem_wr_qual", bus.mem_wr & ~bus.mem_en, 0);
      if (bus.if_gnt || bus.d_gnt || bus.if_done || bus.d_done) check("busy", bus.busy, 1);
      if (bus.if_gnt || bus.d_gnt) begin
        check("gnt_onehot", bus.if_gnt & bus.d_gnt, 0);
        if (log_gnt) begin
          gl_who.push_back(bus.d_gnt);
          gl_cyc.push_back(cyc);
        end
      end
      prev_en = bus.mem_en;
    end
  end

  task automatic fetch_txn(input logic [AW-1:0] a, output int lat);
    resp_t e;
    e.err   = a[0];
    e.rdata = a[0] ? 16'h0 : ref_mem[a[8:1]];
    fq.push_back(e);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.if_gnt && lat < 100);
    check("if_gnt_seen", bus.if_gnt, 1);
    if (bus.if_gnt) begin
      check("if_mem_en", bus.mem_en, !a[0]);
      if (!a[0]) check("if_mem_bus", {bus.mem_wr, bus.mem_addr}, {1'b0, a});
      @(negedge clk);
      check("if_done_lat", bus.if_done, 1);
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0;
  endtask

  task automatic data_txn(input logic wr, input logic [AW-1:0] a, input logic [15:0] wd,
                          output int lat);
    resp_t e;
    e.err   = a[0];
    e.rdata = (a[0] || wr) ? 16'h0 : ref_mem[a[8:1]];
    if (wr && !a[0]) ref_mem[a[8:1]] = wd;
    dq.push_back(e);
    bus.d_req   = 1'b1;
    bus.d_wr    = wr;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.d_gnt && lat < 100);
    check("d_gnt_seen", bus.d_gnt, 1);
    if (bus.d_gnt) begin
      check("d_mem_en", bus.mem_en, !a[0]);
      if (!a[0]) check("d_mem_bus", {bus.mem_wr, bus.mem_addr}, {wr, a});
      if (!a[0] && wr) check("d_mem_wdata", bus.mem_wdata, wd);
      @(negedge clk);
      check("d_done_lat", bus.d_done, 1);
    end
    @(posedge clk); #1;
    bus.d_req = 1'b0;
  endtask

  // both ports request from the same IDLE cycle and keep requesting
  task automatic contention();
    int lf, ld;
    gl_who.delete();
    gl_cyc.delete();
    log_gnt = 1'b1;
    fork
      for (int i = 0; i < 2; i++) fetch_txn(AW'($urandom_range(0, 15) * 2), lf);
      for (int j = 0; j < 2 * SL; j++)
        data_txn(1'($urandom_range(0, 1)), AW'(32 + $urandom_range(0, 200) * 2), 16'($urandom), ld);
    join
    log_gnt = 1'b0;
    check("cont_count", gl_who.size(), 2 * (SL + 1));
    for (int k = 0; k < gl_who.size() && k < 2 * (SL + 1); k++) begin
      // every (SL+1)-th grant goes to fetch, the rest to data
      check($sformatf("cont_order%0d", k), gl_who[k], ((k + 1) % (SL + 1)) != 0);
      if (k > 0) check("cont_spacing", gl_cyc[k] - gl_cyc[k-1], 3);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, w0, e0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8]     = 16'h1234;
    ref_mem[8] = 16'h1234;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = 16'h0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // single fetch
    fetch_txn(16'h0010, lat);
    check("if_latency", lat, 2);

    // write then read back
    w0 = wr_cnt;
    data_txn(1'b1, 16'h0020, 16'hBEEF, lat);
    check("d_latency", lat, 2);
    check("wr_pulses", wr_cnt - w0, 1);
    data_txn(1'b0, 16'h0020, 16'h0, lat);

    // misaligned write
    e0 = en_cnt;
    data_txn(1'b1, 16'h0021, 16'h1111, lat);
    check("misal_no_en", en_cnt - e0, 0);
    check("mem_0020", mem[16], 16'hBEEF);
    data_txn(1'b0, 16'h0020, 16'h0, lat);

    // reset asserted during the ACCESS cycle of a fetch read
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0004;
    @(negedge clk);
    @(negedge clk);
    check("rst_op_gnt", bus.if_gnt, 1);
    rst        = 1'b0;
    bus.if_req = 1'b0;
    @(negedge clk);
    check("rst_op_no_done", bus.if_done, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    fetch_txn(16'h0010, lat);

    // random traffic on both ports
    fork
      for (int i = 0; i < 30; i++) begin
        int lf;
        fetch_txn(AW'($urandom_range(0, 31)), lf);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      for (int j = 0; j < 40; j++) begin
        int ld;
        data_txn(1'($urandom_range(0, 1)), AW'($urandom_range(32, 511)), 16'($urandom), ld);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
    join

    // idle
    repeat (20) begin
      @(negedge clk);
      check("idle_busy_en", {bus.busy, bus.mem_en}, 0);
    end
    check("idle_starve", dut.starve_cnt, 0);

    @(posedge clk); #1;
    contention();

    repeat (4) @(negedge clk);
    check("fq_empty", fq.size(), 0);
    check("dq_empty", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and access sequencer for the single-ported, byte-addressable, 16-bit-wide instruction/data memory. It sits between the fetch stage (read-only) and the memory stage (read/write) of the single-memory processor configuration. It serialises their accesses so the memory never sees concurrent read and write, and it rejects misaligned addresses. Each transaction is a fixed three-cycle req → gnt → done sequence; fairness is bounded by a starvation counter.

## Interface
Parameters:
- ADDR_WIDTH, 16, byte-address width of all address ports
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (range 1–15)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- if_req  in  1  fetch request, level
- if_addr  in  ADDR_WIDTH  fetch byte address
- if_gnt  out  1  fetch request accepted (one-cycle pulse)
- if_done  out  1  fetch complete, if_rdata/if_err valid (one-cycle pulse)
- if_rdata  out  16  fetch read data
- if_err  out  1  fetch address misaligned (qualified by if_done)
- d_req  in  1  data request, level
- d_wr  in  1  1 = write, 0 = read
- d_addr  in  ADDR_WIDTH  data byte address
- d_wdata  in  16  write data
- d_gnt, d_done, d_rdata[15:0], d_err  out  as for fetch port
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, combinational from mem_addr
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP; every output is decoded from registered state.
- IDLE:
  - Samples both req lines; if either is high, latch owner, addr, wr (fetch: wr=0) and wdata, then go to ACCESS.
  - Both requesting: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- ACCESS:
  - gnt of the owner = 1.
  - If latched addr[0] == 0: mem_en = 1, mem_wr = latched wr, mem_addr/mem_wdata = latched values. Read data is captured from mem_rdata at the end of this cycle.
  - If addr[0] == 1: mem_en = 0, err flag is latched, and the captured rdata is 0.
  - Next state is RESP.
- RESP:
  - done of the owner = 1; rdata and err of the owner are valid.
  - Reads return the captured word; writes return rdata = 0.
  - Req lines are ignored. Next state is IDLE.
- Requester protocol:
  - Hold req, addr, wr and wdata stable from assertion through gnt.
  - After done, either present a new request or deassert req by the following IDLE cycle.
- starve_cnt (4 bits):
  - Increments when data is granted while if_req is high, saturating at STARVE_LIMIT.
  - Clears when fetch is granted or when if_req is low in IDLE.
- Outside ACCESS: mem_en = mem_wr = 0, and mem_addr/mem_wdata hold their last values.
- Per-port rdata and err hold their values until the next done on that port.

## Timing
- Reset values: state IDLE, starve_cnt 0. All gnt, done, err, mem_en, mem_wr and busy are 0. if_rdata, d_rdata, mem_addr and mem_wdata are 0.
- Latency: req high in IDLE cycle N → gnt in cycle N+1 → done in cycle N+2. Earliest next grant is cycle N+4; throughput is one access per 3 cycles.
- Exactly one memory access per transaction; mem_en is never high in two consecutive cycles.
- Reset mid-transaction:
  - rst low at the edge ending ACCESS: a write strobed in that cycle commits to memory, no done is issued, and all registers clear.
  - rst low during RESP: done completes in that cycle, then the block clears.
- During reset, mem_en = 0 so the memory image load is never disturbed.
- A req deasserted before gnt is undefined use; the bench must not do it.

## Test plan
- Single fetch: if_req=1, if_addr=0x0010, memory word 0x1234 → if_gnt at N+1, mem_en=1 and mem_addr=0x0010 at N+1, if_done at N+2 with if_rdata=0x1234, if_err=0.
- Write then read: d_wr=1, d_addr=0x0020, d_wdata=0xBEEF; then a read of 0x0020 → mem_wr pulses once; the second d_done returns d_rdata=0xBEEF.
- Contention:
  - Setup: if_req and d_req held high continuously, STARVE_LIMIT=4.
  - Required grant order: D,D,D,D,F,D,D,D,D,F…
  - Required spacing: grants exactly 3 cycles apart, with never more than 4 consecutive D grants.
- Misaligned: d_addr=0x0021 with d_wr=1 → mem_en stays 0, d_done with d_err=1 and d_rdata=0; the memory contents at 0x0020 are unchanged.
- Reset mid-op: rst=0 asserted in an ACCESS cycle of a read → no if_done, outputs match the reset values next cycle. After release, a new request completes normally.
- Idle: both req low for 20 cycles → busy=0 and mem_en=0 throughout, starve_cnt stays 0.
